// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit bus between the pipeline datapath and the controller (HAZ_PERF_CNT_EN adds counter outputs)
interface pipe_hazard_ctrl_if;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy, MemErr;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemBusy, MemErr, StallCycles, FlushCount
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemBusy, MemErr, StallCycles, FlushCount
  );
`else
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemBusy, MemErr
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           MemBusy, MemErr
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage ARM hazard unit with forwarding, load-use/branch control and a memory wait-state FSM
// HAZ_PERF_CNT_EN adds saturating StallCycles/FlushCount counters
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TCNT_W      = 8
) (
  input logic          CLK,
  input logic          RST,
  pipe_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
  state_t            r_state, w_state_nxt;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic              r_err, w_err_nxt, w_mem_stall, w_ldr_stall, w_pc_pend;
  logic [1:0]        w_fwd_a, w_fwd_b;
  assign w_fwd_a = (h.RegWriteM && h.WA3M == h.RA1E && h.RA1E != 4'd15) ? 2'b10 :
                   (h.RegWriteW && h.WA3W == h.RA1E && h.RA1E != 4'd15) ? 2'b01 : 2'b00;
  assign w_fwd_b = (h.RegWriteM && h.WA3M == h.RA2E && h.RA2E != 4'd15) ? 2'b10 :
                   (h.RegWriteW && h.WA3W == h.RA2E && h.RA2E != 4'd15) ? 2'b01 : 2'b00;
  assign w_ldr_stall = h.MemtoRegE && (h.WA3E == h.RA1D || h.WA3E == h.RA2D);
  assign w_pc_pend   = h.PCSrcD | h.PCSrcE | h.PCSrcM;
  // Ready beats timeout in the same cycle, so an access completing on the last allowed cycle is not an error
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err;
    w_mem_stall = 1'b0;
    if (r_state == IDLE) begin
      w_mem_stall = h.MemReqM && !h.MemReadyM;
      if (w_mem_stall) begin
        w_state_nxt = WAIT;
        w_tcnt_nxt  = TCNT_W'(1);
      end
    end else if (h.MemReadyM) begin
      w_state_nxt = IDLE;
      w_tcnt_nxt  = '0;
    end else if (r_tcnt == TCNT_W'(MEM_TIMEOUT)) begin
      w_state_nxt = IDLE;
      w_tcnt_nxt  = '0;
      w_err_nxt   = 1'b1;
    end else begin
      w_mem_stall = 1'b1;
      w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_err   <= w_err_nxt;
    end
  end
  // A memory freeze holds every stage; load-use and branch decisions wait until release
  always_comb begin
    h.StallF = 1'b0;
    h.StallD = 1'b0;
    h.StallE = 1'b0;
    h.StallM = 1'b0;
    h.FlushD = 1'b0;
    h.FlushE = 1'b0;
    h.FlushW = 1'b0;
    if (RST) begin
      h.FlushD = 1'b1;
      h.FlushE = 1'b1;
      h.FlushW = 1'b1;
    end else if (w_mem_stall) begin
      h.StallF = 1'b1;
      h.StallD = 1'b1;
      h.StallE = 1'b1;
      h.StallM = 1'b1;
      h.FlushW = 1'b1;
    end else if (w_ldr_stall) begin
      h.StallF = 1'b1;
      h.StallD = 1'b1;
      h.FlushE = 1'b1;
      h.FlushD = h.BranchTakenE;
    end else begin
      h.StallF = w_pc_pend;
      h.FlushD = w_pc_pend | h.BranchTakenE;
      h.FlushE = h.BranchTakenE;
    end
  end
  assign h.ForwardAE = RST ? 2'b00 : w_fwd_a;
  assign h.ForwardBE = RST ? 2'b00 : w_fwd_b;
  assign h.MemBusy   = !RST && r_state == WAIT;
  assign h.MemErr    = r_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (h.StallF && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (h.FlushE && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
  assign h.StallCycles = r_stall_cnt;
  assign h.FlushCount  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, stalls, flushes, wait-state FSM and timeout
module tb_pipe_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int errors = 0;
  int checks = 0;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TCNT_W(8)) dut (.CLK(CLK), .RST(RST), .h(bus.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] ctl();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic clear_in();
    {bus.RA1D, bus.RA2D, bus.RA1E, bus.RA2E, bus.WA3E, bus.WA3M, bus.WA3W} = '0;
    {bus.RegWriteM, bus.RegWriteW, bus.MemtoRegE, bus.PCSrcD, bus.PCSrcE, bus.PCSrcM} = '0;
    {bus.BranchTakenE, bus.MemReqM, bus.MemReadyM} = '0;
  endtask
  initial begin
    clear_in();
    RST = 1'b1;
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd3; bus.RA1E = 4'd3; bus.RA2E = 4'd3;
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd5; bus.RA2D = 4'd5; bus.PCSrcD = 1'b1; bus.MemReqM = 1'b1;
    #1;
    chk("rst_ctl", 32'(ctl()), 32'b0000111);
    chk("rst_fwdA", 32'(bus.ForwardAE), 32'd0);
    chk("rst_fwdB", 32'(bus.ForwardBE), 32'd0);
    chk("rst_busy", 32'(bus.MemBusy), 32'd0);
    tick(); tick();
    RST = 1'b0; clear_in(); #1;
    chk("idle_ctl", 32'(ctl()), 32'd0);
    chk("idle_err", 32'(bus.MemErr), 32'd0);
    chk("idle_busy", 32'(bus.MemBusy), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall0", bus.StallCycles, 32'd0);
    chk("perf_flush0", bus.FlushCount, 32'd0);
`endif
    // wait states: ready low for 3 cycles, load-use raised during the freeze
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; #1;
    chk("ws1_ctl", 32'(ctl()), 32'b1111001);
    chk("ws1_busy", 32'(bus.MemBusy), 32'd0);
    tick();
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd5; bus.RA1D = 4'd5; #1;
    chk("ws2_ctl", 32'(ctl()), 32'b1111001);
    chk("ws2_busy", 32'(bus.MemBusy), 32'd1);
    tick();
    chk("ws3_ctl", 32'(ctl()), 32'b1111001);
    chk("ws3_busy", 32'(bus.MemBusy), 32'd1);
    tick();
    bus.MemReadyM = 1'b1; #1;
    chk("ws_rel_ctl", 32'(ctl()), 32'b1100010);
    chk("ws_rel_err", 32'(bus.MemErr), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall3", bus.StallCycles, 32'd3);
`endif
    tick();
    clear_in(); #1;
    chk("ws_after_ctl", 32'(ctl()), 32'd0);
    chk("ws_after_busy", 32'(bus.MemBusy), 32'd0);
    chk("ws_after_err", 32'(bus.MemErr), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall4", bus.StallCycles, 32'd4);
    chk("perf_flush1", bus.FlushCount, 32'd1);
`endif
    // forwarding
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd3; bus.RegWriteW = 1'b1; bus.WA3W = 4'd3;
    bus.RA1E = 4'd3; bus.RA2E = 4'd15; #1;
    chk("fwd_m_A", 32'(bus.ForwardAE), 32'd2);
    chk("fwd_r15_B", 32'(bus.ForwardBE), 32'd0);
    bus.RegWriteM = 1'b0; #1;
    chk("fwd_w_A", 32'(bus.ForwardAE), 32'd1);
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd9; bus.WA3W = 4'd7; bus.RA1E = 4'd7; bus.RA2E = 4'd9; #1;
    chk("fwd_w_A2", 32'(bus.ForwardAE), 32'd1);
    chk("fwd_m_B2", 32'(bus.ForwardBE), 32'd2);
    bus.WA3M = 4'd15; bus.WA3W = 4'd15; bus.RA1E = 4'd15; #1;
    chk("fwd_r15_A", 32'(bus.ForwardAE), 32'd0);
    clear_in();
    // load-use for one cycle
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd5; bus.RA2D = 4'd5; #1;
    chk("ldr_ctl", 32'(ctl()), 32'b1100010);
    tick();
    bus.MemtoRegE = 1'b0; #1;
    chk("ldr_done_ctl", 32'(ctl()), 32'd0);
    // branches
    bus.BranchTakenE = 1'b1; bus.PCSrcE = 1'b1; #1;
    chk("br_taken_ctl", 32'(ctl()), 32'b1000110);
    tick();
    bus.BranchTakenE = 1'b0; bus.PCSrcE = 1'b0; bus.PCSrcD = 1'b1; #1;
    chk("br_pcsrcd_ctl", 32'(ctl()), 32'b1000100);
    tick();
    bus.PCSrcD = 1'b0; bus.MemtoRegE = 1'b1; bus.WA3E = 4'd2; bus.RA1D = 4'd2; bus.BranchTakenE = 1'b1; #1;
    chk("ldr_br_ctl", 32'(ctl()), 32'b1100110);
    tick();
    clear_in();
    // timeout: 4 stalled cycles, release on the fifth
    bus.MemReqM = 1'b1; #1;
    chk("to1_ctl", 32'(ctl()), 32'b1111001);
    tick();
    chk("to2_ctl", 32'(ctl()), 32'b1111001);
    tick();
    chk("to3_ctl", 32'(ctl()), 32'b1111001);
    tick();
    chk("to4_ctl", 32'(ctl()), 32'b1111001);
    chk("to4_err", 32'(bus.MemErr), 32'd0);
    tick();
    chk("to5_ctl", 32'(ctl()), 32'd0);
    chk("to5_busy", 32'(bus.MemBusy), 32'd1);
    tick();
    bus.MemReqM = 1'b0; #1;
    chk("to_err_set", 32'(bus.MemErr), 32'd1);
    chk("to_busy_off", 32'(bus.MemBusy), 32'd0);
    tick(); tick();
    chk("to_err_sticky", 32'(bus.MemErr), 32'd1);
    RST = 1'b1; tick();
    RST = 1'b0; #1;
    chk("to_err_clr", 32'(bus.MemErr), 32'd0);
    // ready on the timeout cycle wins
    bus.MemReqM = 1'b1; tick(); tick(); tick(); tick();
    bus.MemReadyM = 1'b1; #1;
    chk("rdy_to_ctl", 32'(ctl()), 32'd0);
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0; #1;
    chk("rdy_to_err", 32'(bus.MemErr), 32'd0);
    // reset in the middle of WAIT
    bus.MemReqM = 1'b1; tick(); tick();
    chk("mid_busy", 32'(bus.MemBusy), 32'd1);
    RST = 1'b1; #1;
    chk("mid_rst_ctl", 32'(ctl()), 32'b0000111);
    chk("mid_rst_busy", 32'(bus.MemBusy), 32'd0);
    tick();
    RST = 1'b0; bus.MemReqM = 1'b0; #1;
    chk("mid_after_busy", 32'(bus.MemBusy), 32'd0);
    chk("mid_after_err", 32'(bus.MemErr), 32'd0);
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1; #1;
    chk("zero_wait_ctl", 32'(ctl()), 32'd0);
    tick();
    chk("zero_wait_busy", 32'(bus.MemBusy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
